// File: rtl/systolic_tile_sequencer_pkg.sv
// Shared types and default geometry for the systolic tile sequencer.
// The state enum and default widths are the single source for RTL and bench.
package systolic_seq_pkg;

  localparam int ARRAY_DIM = 8;
  localparam int DATA_W    = 128;
  localparam int TILE_W    = 16;
  localparam int K_W       = 20;

  typedef enum logic [2:0] {
    IDLE,
    START,
    FEED,
    DRAIN,
    RESP
  } state_e;

endpackage

// File: rtl/systolic_tile_sequencer_if.sv
// Command, response and stream bundle between the sequencer and its neighbours.
// master is the sequencer side, slave is the front end / array / sink side.
interface systolic_tile_sequencer_if
  import systolic_seq_pkg::*;
#(
  parameter int DW = systolic_seq_pkg::DATA_W,
  parameter int TW = systolic_seq_pkg::TILE_W,
  parameter int KW = systolic_seq_pkg::K_W
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [TW-1:0] cmd_tiles;
  logic [KW-1:0] cmd_inner_dim;

  logic          resp_valid;
  logic          resp_ready;
  logic [TW-1:0] resp_tiles;
  logic          resp_err;

  logic [DW-1:0] src_act;
  logic          src_act_valid;
  logic          src_act_ready;
  logic [DW-1:0] src_wgt;
  logic          src_wgt_valid;
  logic          src_wgt_ready;

  logic [DW-1:0] arr_act;
  logic          arr_act_valid;
  logic          arr_act_ready;
  logic [DW-1:0] arr_wgt;
  logic          arr_wgt_valid;
  logic          arr_wgt_ready;

  logic          arr_start;
  logic          arr_start_ready;
  logic [KW-1:0] arr_inner_dim;

  logic [DW-1:0] arr_out;
  logic          arr_out_valid;
  logic          arr_out_ready;

  logic [DW-1:0] dst_out;
  logic          dst_out_valid;
  logic          dst_out_ready;
  logic          dst_last_row;
  logic          dst_last_tile;

  modport master (
    input  cmd_valid, cmd_tiles, cmd_inner_dim,
    output cmd_ready,
    output resp_valid, resp_tiles, resp_err,
    input  resp_ready,
    input  src_act, src_act_valid, src_wgt, src_wgt_valid,
    output src_act_ready, src_wgt_ready,
    output arr_act, arr_act_valid, arr_wgt, arr_wgt_valid,
    input  arr_act_ready, arr_wgt_ready,
    output arr_start, arr_inner_dim,
    input  arr_start_ready,
    input  arr_out, arr_out_valid,
    output arr_out_ready,
    output dst_out, dst_out_valid, dst_last_row, dst_last_tile,
    input  dst_out_ready
  );

  modport slave (
    output cmd_valid, cmd_tiles, cmd_inner_dim,
    input  cmd_ready,
    input  resp_valid, resp_tiles, resp_err,
    output resp_ready,
    output src_act, src_act_valid, src_wgt, src_wgt_valid,
    input  src_act_ready, src_wgt_ready,
    input  arr_act, arr_act_valid, arr_wgt, arr_wgt_valid,
    output arr_act_ready, arr_wgt_ready,
    input  arr_start, arr_inner_dim,
    output arr_start_ready,
    output arr_out, arr_out_valid,
    input  arr_out_ready,
    input  dst_out, dst_out_valid, dst_last_row, dst_last_tile,
    output dst_out_ready
  );

endinterface

// File: rtl/systolic_tile_sequencer.sv
// Runs a multi-tile matmul job: one array start per tile, exactly K paired
// act/wgt beats per tile, then ARRAY_DIM drained rows marked with tile/job ends.
module systolic_tile_sequencer
  import systolic_seq_pkg::*;
#(
  parameter int ARRAY_DIM = systolic_seq_pkg::ARRAY_DIM,
  parameter int DATA_W    = systolic_seq_pkg::DATA_W,
  parameter int TILE_W    = systolic_seq_pkg::TILE_W,
  parameter int K_W       = systolic_seq_pkg::K_W
) (
  input logic clk,
  input logic rst,
  systolic_tile_sequencer_if.master bus
);

  localparam int ROW_W = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ARRAY_DIM - 1);

  state_e            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [K_W-1:0]    beat_q, beat_d;
  logic [TILE_W-1:0] left_q, left_d;
  logic [TILE_W-1:0] done_q, done_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              err_q, err_d;

  logic pair_v;
  logic beat_acc;
  logic row_xfer;
  logic last_row;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    beat_d  = beat_q;
    left_d  = left_q;
    done_d  = done_q;
    row_d   = row_q;
    err_d   = err_q;

    pair_v   = bus.src_act_valid && bus.src_wgt_valid;
    beat_acc = 1'b0;
    row_xfer = 1'b0;
    last_row = 1'b0;

    bus.cmd_ready     = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.resp_tiles    = '0;
    bus.resp_err      = 1'b0;
    bus.src_act_ready = 1'b0;
    bus.src_wgt_ready = 1'b0;
    bus.arr_act       = '0;
    bus.arr_wgt       = '0;
    bus.arr_act_valid = 1'b0;
    bus.arr_wgt_valid = 1'b0;
    bus.arr_start     = 1'b0;
    bus.arr_inner_dim = k_q;
    bus.arr_out_ready = 1'b0;
    bus.dst_out       = '0;
    bus.dst_out_valid = 1'b0;
    bus.dst_last_row  = 1'b0;
    bus.dst_last_tile = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          k_d    = bus.cmd_inner_dim;
          left_d = bus.cmd_tiles;
          done_d = '0;
          if (bus.cmd_tiles == '0 || bus.cmd_inner_dim == '0) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = START;
          end
        end
      end
      START: begin
        bus.arr_start = bus.arr_start_ready;
        if (bus.arr_start_ready) begin
          beat_d  = k_q;
          state_d = FEED;
        end
      end
      FEED: begin
        // Streams only move as a pair, and only when both array lanes take it.
        beat_acc          = pair_v && bus.arr_act_ready && bus.arr_wgt_ready;
        bus.arr_act       = bus.src_act;
        bus.arr_wgt       = bus.src_wgt;
        bus.arr_act_valid = pair_v;
        bus.arr_wgt_valid = pair_v;
        bus.src_act_ready = beat_acc;
        bus.src_wgt_ready = beat_acc;
        if (beat_acc) begin
          beat_d = beat_q - 1'b1;
          if (beat_q == K_W'(1)) begin
            row_d   = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        row_xfer          = bus.arr_out_valid && bus.dst_out_ready;
        last_row          = (row_q == LAST_ROW);
        bus.dst_out       = bus.arr_out;
        bus.dst_out_valid = bus.arr_out_valid;
        bus.arr_out_ready = bus.dst_out_ready;
        bus.dst_last_row  = last_row;
        bus.dst_last_tile = last_row && (left_q == TILE_W'(1));
        if (row_xfer) begin
          row_d = row_q + 1'b1;
          if (last_row) begin
            row_d   = '0;
            done_d  = done_q + 1'b1;
            left_d  = left_q - 1'b1;
            state_d = (left_q == TILE_W'(1)) ? RESP : START;
          end
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_tiles = done_q;
        bus.resp_err   = err_q;
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      left_q  <= '0;
      done_q  <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      left_q  <= left_d;
      done_q  <= done_d;
      row_q   <= row_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/systolic_tile_sequencer.md
# systolic_tile_sequencer

Sequences a multi-tile matmul job onto the 8x8 output-stationary systolic array. It accepts one job command (tile count, inner dimension K), starts the array once per tile, and gates the paired activation/weight streams so exactly K beats enter per tile. It counts the 8 accumulator rows drained per tile, marks tile/job boundaries on the output stream, and returns a completion response. It sits between the DMA/stream front end and the array's ctrl/act/wgt/accumulator ports.

## Interface
Parameters:
- ARRAY_DIM, 8, rows drained per tile (array is ARRAY_DIM x ARRAY_DIM)
- DATA_W, 128, act/wgt/accumulator bus width
- TILE_W, 16, width of tile count
- K_W, 20, width of inner dimension

Ports:
- clk  in  1  clock; everything on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid / cmd_ready  in / out  1 / 1  job command handshake
- cmd_tiles  in  TILE_W  output tiles in job
- cmd_inner_dim  in  K_W  K beats per tile
- resp_valid / resp_ready  out / in  1 / 1  completion handshake
- resp_tiles  out  TILE_W  tiles completed
- resp_err  out  1  job rejected (zero tiles or zero K)
- src_act, src_wgt  in  DATA_W  upstream streams, each with src_*_valid in / src_*_ready out
- arr_act, arr_wgt  out  DATA_W  to array, each with arr_*_valid out / arr_*_ready in
- arr_start  out  1  array ctrl_start_matmul
- arr_start_ready  in  1  array ctrl_start_ready
- arr_inner_dim  out  K_W  array ctrl_inner_dimension
- arr_out, arr_out_valid / arr_out_ready  in, in / out  DATA_W, 1 / 1  array accumulator stream
- dst_out, dst_out_valid / dst_out_ready  out, out / in  DATA_W, 1 / 1  downstream
- dst_last_row  out  1  qualifies dst beat: last row of tile
- dst_last_tile  out  1  qualifies dst beat: last row of last tile

## Operation
- States: IDLE, START, FEED, DRAIN, RESP.
- IDLE: cmd_ready=1. On cmd fire: latch tiles, K; if either is 0, go to RESP with resp_err=1 and resp_tiles=0; else go to START with tiles_left=tiles, done=0.
- START: arr_start=arr_start_ready; on arr_start&&arr_start_ready load beat_ctr=K and go to FEED. arr_inner_dim is driven from the latched K in all states.
- FEED: fire = src_act_valid && src_wgt_valid; arr_*_valid=fire; src_*_ready = fire && arr_act_ready && arr_wgt_ready. Each accepted beat decrements beat_ctr; the beat taking it to 0 moves to DRAIN, row_ctr=0. Outside FEED, all src_*_ready and arr_*_valid are 0 (no beat of the next tile leaks in).
- DRAIN: dst_out=arr_out, dst_out_valid=arr_out_valid, arr_out_ready=dst_out_ready (combinational pass-through, DRAIN only; 0 elsewhere). Each transferred row increments row_ctr. Row ARRAY_DIM-1 asserts dst_last_row; if also tiles_left==1, it asserts dst_last_tile. On that beat: done++, tiles_left--; go to RESP if tiles_left was 1, else START.
- RESP: resp_valid=1, resp_tiles=done, held stable until resp_ready, then IDLE.
- Counters are full width; K up to 2^K_W-1 and tiles up to 2^TILE_W-1 are legal, with no wrap.

## Timing
- Reset (async assert, sync release) puts the block in IDLE with counters 0. Outputs during reset: cmd_ready=1; all valids, arr_start, resp_err, dst_last_* are 0; data outputs are 0.
- Command accept to first arr_start: 1 cycle, if arr_start_ready is already 1.
- arr_start is at most a 1-cycle pulse per tile.
- Throughput: 1 beat/cycle in FEED and in DRAIN.
- Per-tile overhead: START→FEED is 1 cycle after the start handshake. The array's internal drain latency is absorbed by waiting in DRAIN on arr_out_valid.
- Reset asserted mid-job: return to IDLE immediately with no response. The array is reset by the same rst.
- resp_valid stalls the block; no new command is accepted until the response is taken.

## Structure
- Package systolic_seq_pkg holds: the state enum (IDLE, START, FEED, DRAIN, RESP), ARRAY_DIM, and the default widths.
- Single module; counters are inline. No sub-module.

## Test plan
- tiles=1, K=4, streams always valid, dst_ready=1 → exactly 4 arr beats; one arr_start; 8 dst beats with last_row and last_tile on the 8th; resp_tiles=1, err=0.
- tiles=3, K=16, random valid/ready stalls on src, arr and dst → 48 act/wgt beats total; 3 starts; 24 dst beats; last_row on beats 8/16/24, last_tile only on 24; resp_tiles=3.
- src_act valid but src_wgt invalid for 10 cycles in FEED → no beat forwarded, beat_ctr unchanged, no src_*_ready.
- cmd with K=0 (and separately tiles=0) → no arr_start; resp_valid next cycle with err=1, tiles=0.
- Extra src beats queued after the K-th beat → src_*_ready stays 0 through DRAIN until the next START handshake.
- rst pulsed during DRAIN of tile 2 of 4 → IDLE at once, cmd_ready=1, no resp; a new job then completes normally.
